// File: rtl/fetch_pkg.sv
// Shared defaults and entry type for the instruction prefetch queue.
package fetch_pkg;
    localparam int ADDR_W    = 5;
    localparam int INST_W    = 32;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Memory, pipeline-control and IF/ID-facing signals of the fetch queue.
interface fetch_queue_if import fetch_pkg::*; #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INST_W = fetch_pkg::INST_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W:0]   redirect_pc;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              done;

    modport master (
        output mem_addr, out_valid, out_pc, out_inst, done,
        input  mem_inst, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  mem_addr, out_valid, out_pc, out_inst, done,
        output mem_inst, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO of fetch entries with a single-cycle flush.
module fetch_fifo import fetch_pkg::*; #(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = fetch_pkg::DEPTH,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           din,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] hd_ptr, tl_ptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_ptr <= '0;
            tl_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            hd_ptr <= '0;
            tl_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) tl_ptr <= tl_ptr + 1'b1;
            if (pop)  hd_ptr <= hd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tl_ptr] <= din;
    end

    assign head = mem[hd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: walks fetch_pc through memory, queues {pc, inst}
// pairs and presents the head to IF/ID; redirect flushes and refetches.
module fetch_queue import fetch_pkg::*; #(
    parameter int  ADDR_W = fetch_pkg::ADDR_W,
    parameter int  INST_W = fetch_pkg::INST_W,
    parameter int  DEPTH  = fetch_pkg::DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         rst_n,
    fetch_queue_if.master bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [ADDR_W:0]  fetch_pc;
    logic [CNT_W-1:0] count;
    logic             push, pop, out_valid, in_range, full;
    entry_t           head, din;

    // The extra MSB marks end-of-program, so fetch never wraps.
    assign in_range  = !fetch_pc[ADDR_W];
    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && !bus.stall && !bus.redirect_valid;
    assign push      = !bus.redirect_valid && in_range && (!full || pop);
    assign din       = '{pc: fetch_pc[ADDR_W-1:0], inst: bus.mem_inst};

    fetch_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (din),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  fetch_pc <= '0;
        else if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
        else if (push)               fetch_pc <= fetch_pc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.done <= 1'b0;
        else        bus.done <= !in_range && (count == '0) && !bus.redirect_valid;
    end

    // Empty queue presents zeros so IF/ID loads a NOP-equivalent.
    assign bus.mem_addr  = fetch_pc[ADDR_W-1:0];
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? head.pc   : '0;
    assign bus.out_inst  = out_valid ? head.inst : '0;
endmodule
